// File: rtl/pll_phase_ctrl_if.sv
// Host-side request/response channel of the PLL phase controller.
// The request field is one bit wider than a phase index so that out-of-range targets can be expressed and rejected.
interface pll_phase_ctrl_if #(
    parameter int PHASE_STEPS = 64
);
    localparam int PW = $clog2(PHASE_STEPS);

    logic          req_valid;
    logic [PW:0]   req_phase;
    logic          req_ready;
    logic          done;
    logic          err;
    logic          busy;
    logic [PW-1:0] cur_phase;

    modport master (
        output req_valid, req_phase,
        input  req_ready, done, err, busy, cur_phase
    );

    modport slave (
        input  req_valid, req_phase,
        output req_ready, done, err, busy, cur_phase
    );
endinterface

// File: rtl/pll_phase_ctrl.sv
// Dynamic phase controller for one PLL output: walks the phase to a requested
// position by the shortest path, one PSSEL/PSDIR/PSPULSE step at a time.
module pll_phase_ctrl #(
    parameter int CHANNEL     = 2,
    parameter int PHASE_STEPS = 64,
    parameter int INIT_PHASE  = 51,
    parameter int SETUP_CYC   = 2,
    parameter int PULSE_CYC   = 4,
    parameter int GAP_CYC     = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 pll_lock,
    pll_phase_ctrl_if.slave      host,
    output logic [2:0]           ps_sel,
    output logic                 ps_dir,
    output logic                 ps_pulse,
    output logic                 locked
);
    localparam int PW          = $clog2(PHASE_STEPS);
    localparam int SYNC_STAGES = 2;
    localparam int MAX_CYC     = (SETUP_CYC > PULSE_CYC)
                               ? ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC)
                               : ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);
    localparam int CW          = $clog2(MAX_CYC) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [PW-1:0]   steps_reg;
    logic            sync_reg [SYNC_STAGES];

    int              req_int;
    int              cur_int;
    int              up_int;
    int              dn_int;
    logic            dir_next;
    logic [PW-1:0]   steps_next;
    logic [PW-1:0]   phase_inc;
    logic [PW-1:0]   phase_dec;

    // Lock synchronizer; LOCK is asynchronous to clk.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn) sync_reg[gi] <= 1'b0;
                    else         sync_reg[gi] <= pll_lock;
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn) sync_reg[gi] <= 1'b0;
                    else         sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign locked = sync_reg[SYNC_STAGES-1];

    // Shortest path around the circle; an exact half-circle tie increments.
    always_comb begin
        req_int    = int'(host.req_phase);
        cur_int    = int'(host.cur_phase);
        up_int     = (req_int >= cur_int) ? (req_int - cur_int)
                                          : (req_int + PHASE_STEPS - cur_int);
        dn_int     = PHASE_STEPS - up_int;
        dir_next   = (up_int > dn_int);
        steps_next = dir_next ? PW'(dn_int) : PW'(up_int);
        phase_inc  = (host.cur_phase == PW'(PHASE_STEPS - 1)) ? '0 : host.cur_phase + 1'b1;
        phase_dec  = (host.cur_phase == '0) ? PW'(PHASE_STEPS - 1) : host.cur_phase - 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            steps_reg      <= '0;
            host.req_ready <= 1'b1;
            host.done      <= 1'b0;
            host.err       <= 1'b0;
            host.busy      <= 1'b0;
            host.cur_phase <= PW'(INIT_PHASE);
            ps_sel         <= 3'(CHANNEL);
            ps_dir         <= 1'b0;
            ps_pulse       <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (host.req_valid) begin
                        host.req_ready <= 1'b0;
                        host.busy      <= 1'b1;
                        cnt_reg        <= '0;
                        if (req_int >= PHASE_STEPS) begin
                            host.done <= 1'b1;
                            host.err  <= 1'b1;
                            state_reg <= S_DONE;
                        end else if (req_int == cur_int) begin
                            host.done <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            ps_dir    <= dir_next;
                            steps_reg <= steps_next;
                            state_reg <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    // Stall here without lock; a new step only starts on a locked PLL.
                    if (!locked) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CW'(SETUP_CYC - 1)) begin
                        cnt_reg   <= '0;
                        ps_pulse  <= 1'b1;
                        state_reg <= S_PULSE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_PULSE: begin
                    if (cnt_reg == CW'(PULSE_CYC - 1)) begin
                        cnt_reg        <= '0;
                        ps_pulse       <= 1'b0;
                        host.cur_phase <= ps_dir ? phase_dec : phase_inc;
                        steps_reg      <= steps_reg - 1'b1;
                        state_reg      <= S_GAP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_reg == CW'(GAP_CYC - 1)) begin
                        cnt_reg <= '0;
                        if (steps_reg != '0) begin
                            state_reg <= S_SETUP;
                        end else begin
                            host.done <= 1'b1;
                            state_reg <= S_DONE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    host.done      <= 1'b0;
                    host.err       <= 1'b0;
                    host.busy      <= 1'b0;
                    host.req_ready <= 1'b1;
                    state_reg      <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule
